demultiplekser_wyjsc: RTL and testbench
=======================================

// Module: demultiplekser_wyjsc
// PURPOSE
//  Output-side counterpart of the PLC input multiplexer. The CPU addresses one of
//  eight 8-bit output ports and writes, sets, clears or toggles bits in a shadow
//  (output image) register. A commit strobe transfers all eight shadows to the
//  physical outputs at once, as at the end of a PLC scan cycle.
//  A watchdog forces the outputs to a safe value if commits stop arriving.
// PARAMETERS
//  WDT_CYCLES  1000000  cycles without commit before fault; 0 = watchdog disabled
//  SAFE_VALUE  8'h00    value forced onto every output port on watchdog fault
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst_n        in   1  synchronous reset, active low
//  data_in      in   8  write operand
//  sel          in   3  port address 0..7 (write target and readback source)
//  we           in   1  write strobe, one operation per cycle while high
//  op           in   2  00 write, 01 set bits (OR), 10 clear bits (AND ~), 11 toggle (XOR)
//  commit       in   1  copy shadow bank to outputs; also kicks watchdog
//  clear_fault  in   1  acknowledge watchdog fault
//  out0..out7   out  8  registered physical output ports
//  rd_data      out  8  registered readback of shadow[sel]
//  wdt_fault    out  1  watchdog fault flag
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): shadow[0..7]=0, out0..7=0, rd_data=0,
//    wdt_fault=0, watchdog counter=0. Reset has priority over all inputs;
//    pending operations are discarded.
//  - Shadow update: if we, shadow[sel] <= op(shadow[sel], data_in); visible on
//    rd_data one cycle after the update lands. Other shadows unchanged.
//  - rd_data <= shadow[sel] every cycle (pre-write value in a write cycle).
//  - Commit: out_k <= next-state shadow[k] for all k, so a write and a commit in
//    the same cycle commit the written value. Latency: 1 clk from commit to outputs.
//  - Watchdog counter (32 bit, saturating): commit or clear_fault -> 0; else
//    +1 while not faulted. When it reaches WDT_CYCLES-1 and there is no commit
//    that cycle: wdt_fault <= 1, all out_k <= SAFE_VALUE, counter holds.
//  - While wdt_fault=1: commits do not update outputs (held at SAFE_VALUE);
//    writes to shadows continue normally.
//  - clear_fault: wdt_fault <= 0, counter <= 0; outputs stay at SAFE_VALUE until
//    the next commit. clear_fault and commit in the same cycle: the fault clears
//    and that commit is applied to the outputs.
//  - commit in the expiry cycle wins: no fault is raised.
//  - WDT_CYCLES=0: counter frozen at 0, wdt_fault never asserts.
//  - States: RUN (fault=0) -> FAULT on expiry; FAULT -> RUN on clear_fault.
// TESTING
//  1 Reset: drive rst_n=0 with we=1, commit=1 -> all out_k=0, rd_data=0, wdt_fault=0.
//  2 Write+commit: sel=3, op=00, data=8'hA5, we=1 at cycle 0; commit at cycle 2 ->
//    out3=A5 at cycle 3; others 0; rd_data=A5 with sel=3.
//  3 Bit ops on port 3 (starting at A5): set 0F -> AF, clear A0 -> 0F, toggle FF
//    -> F0; then commit in the same cycle as the toggle -> out3=F0.
//  4 Watchdog, WDT_CYCLES=16, SAFE_VALUE=8'h00: commit at t0, then no commit ->
//    wdt_fault=1 and all out_k=00 16 cycles later; commit in the expiry cycle -> no fault.
//  5 Fault recovery: in FAULT, commit -> outputs stay 00; clear_fault -> fault=0,
//    outputs still 00; next commit -> outputs equal the shadows.
//  6 Reset mid-write: rst_n=0 in the same cycle as we=1 with sel=5 ->
//    shadow[5]=0, readback 00.

Source files
------------

// File: rtl/demultiplekser_wyjsc.sv
// Eight-port PLC output image: per-port write/set/clear/toggle into shadow registers,
// bank commit to the physical outputs, and a commit watchdog that forces a safe value.
module demultiplekser_wyjsc #(
    parameter int unsigned WDT_CYCLES = 1000000,
    parameter logic [7:0]  SAFE_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic [2:0] sel,
    input  logic       we,
    input  logic [1:0] op,
    input  logic       commit,
    input  logic       clear_fault,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [7:0] out4,
    output logic [7:0] out5,
    output logic [7:0] out6,
    output logic [7:0] out7,
    output logic [7:0] rd_data,
    output logic       wdt_fault
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES) - 32'd1;
    localparam logic        WDT_ON   = (WDT_CYCLES != 0);

    logic [7:0]  shadow_q [8];
    logic [7:0]  shadow_d [8];
    logic [7:0]  out_q    [8];
    logic [7:0]  out_d    [8];
    logic [7:0]  rd_data_q, rd_data_d;
    logic [31:0] cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic        expire;

    function automatic logic [7:0] apply_op(input logic [1:0] op_i,
                                            input logic [7:0] cur,
                                            input logic [7:0] din);
        case (op_i)
            2'b00:   apply_op = din;
            2'b01:   apply_op = cur | din;
            2'b10:   apply_op = cur & ~din;
            default: apply_op = cur ^ din;
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            shadow_d[k] = shadow_q[k];
        end
        if (we) begin
            shadow_d[sel] = apply_op(op, shadow_q[sel], data_in);
        end

        rd_data_d = shadow_q[sel];

        // A commit or acknowledge in the last cycle pre-empts the fault.
        expire = WDT_ON && (state_q == RUN) && (cnt_q == WDT_LAST) && !commit && !clear_fault;

        state_d = state_q;
        if (clear_fault) begin
            state_d = RUN;
        end else if (expire) begin
            state_d = FAULT;
        end

        cnt_d = cnt_q;
        if (!WDT_ON || commit || clear_fault) begin
            cnt_d = 32'd0;
        end else if (state_q == RUN && !expire && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end

        // Commits are ignored while faulted unless the fault is acknowledged in the same cycle.
        for (int k = 0; k < 8; k++) begin
            out_d[k] = out_q[k];
            if (expire) begin
                out_d[k] = SAFE_VALUE;
            end else if (commit && (state_q == RUN || clear_fault)) begin
                out_d[k] = shadow_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= 8'h00;
                out_q[k]    <= 8'h00;
            end
            rd_data_q <= 8'h00;
            cnt_q     <= 32'd0;
            state_q   <= RUN;
        end else begin
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= shadow_d[k];
                out_q[k]    <= out_d[k];
            end
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out4      = out_q[4];
    assign out5      = out_q[5];
    assign out6      = out_q[6];
    assign out7      = out_q[7];
    assign rd_data   = rd_data_q;
    assign wdt_fault = (state_q == FAULT);

endmodule

// File: tb/tb_demultiplekser_wyjsc.sv
// Scoreboard bench for demultiplekser_wyjsc: stimulus queues expected values tagged with the
// cycle they are due, a negedge monitor pops and compares them against the DUT.
module tb_demultiplekser_wyjsc;

  localparam int SIG_RD    = 8;
  localparam int SIG_FAULT = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [2:0] sel;
  logic       we;
  logic [1:0] op;
  logic       commit;
  logic       clear_fault;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0] rd_data;
  logic       wdt_fault;

  typedef struct {
    int         due;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t keep[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  demultiplekser_wyjsc #(
    .WDT_CYCLES(16),
    .SAFE_VALUE(8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .sel        (sel),
    .we         (we),
    .op         (op),
    .commit     (commit),
    .clear_fault(clear_fault),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .out6       (out6),
    .out7       (out7),
    .rd_data    (rd_data),
    .wdt_fault  (wdt_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sig_val(input int s);
    case (s)
      0:         sig_val = out0;
      1:         sig_val = out1;
      2:         sig_val = out2;
      3:         sig_val = out3;
      4:         sig_val = out4;
      5:         sig_val = out5;
      6:         sig_val = out6;
      7:         sig_val = out7;
      SIG_RD:    sig_val = rd_data;
      default:   sig_val = {7'd0, wdt_fault};
    endcase
  endfunction

  // Monitor: everything due in the current cycle is compared on the falling edge.
  always @(negedge clk) begin
    keep = {};
    foreach (sbq[i]) begin
      if (sbq[i].due == cyc) begin
        n_check++;
        if (sig_val(sbq[i].sig) !== sbq[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %02h expected %02h",
                   sbq[i].name, cyc, sig_val(sbq[i].sig), sbq[i].val);
        end
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int sig, input logic [7:0] v, input int dly, input string nm);
    exp_t e;
    e.due  = cyc + dly;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  initial begin
    rst_n       = 1'b0;
    data_in     = 8'hFF;
    sel         = 3'd5;
    we          = 1'b1;
    op          = 2'b00;
    commit      = 1'b1;
    clear_fault = 1'b0;
    repeat (3) step();

    n_check++;
    if (out3 !== 8'h00) begin
      n_fail++;
      $display("FAIL direct_reset_out3: got %02h", out3);
    end
    n_check++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL direct_reset_rd: got %02h", rd_data);
    end
    n_check++;
    if (wdt_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset_fault: got %b", wdt_fault);
    end

    // Reset with write and commit active
    for (int k = 0; k < 8; k++) expect_v(k, 8'h00, 0, $sformatf("reset_out%0d", k));
    expect_v(SIG_RD, 8'h00, 0, "reset_rd");
    expect_v(SIG_FAULT, 8'h00, 0, "reset_fault");
    rst_n  = 1'b1;
    we     = 1'b0;
    commit = 1'b0;
    step();

    // Write A5 to port 3, commit two cycles later
    sel = 3'd3; op = 2'b00; data_in = 8'hA5; we = 1'b1;
    expect_v(SIG_RD, 8'h00, 1, "wr_rd_prewrite");
    step();
    we = 1'b0;
    expect_v(SIG_RD, 8'hA5, 1, "wr_rd_a5");
    step();
    commit = 1'b1;
    expect_v(3, 8'hA5, 1, "commit_out3");
    expect_v(0, 8'h00, 1, "commit_out0");
    expect_v(7, 8'h00, 1, "commit_out7");
    step();
    commit = 1'b0;

    // Set / clear / toggle on port 3, toggle committed in the same cycle
    we = 1'b1; op = 2'b01; data_in = 8'h0F;
    expect_v(SIG_RD, 8'hA5, 1, "set_rd_pre");
    step();
    op = 2'b10; data_in = 8'hA0;
    expect_v(SIG_RD, 8'hAF, 1, "set_rd_af");
    step();
    op = 2'b11; data_in = 8'hFF; commit = 1'b1;
    expect_v(SIG_RD, 8'h0F, 1, "clr_rd_0f");
    expect_v(3, 8'hF0, 1, "toggle_commit_out3");
    step();
    we = 1'b0; commit = 1'b0;
    expect_v(SIG_RD, 8'hF0, 1, "toggle_rd_f0");
    step();

    // Port 6 write with same-cycle commit; port 3 must be unaffected
    sel = 3'd6; op = 2'b00; data_in = 8'h3C; we = 1'b1; commit = 1'b1;
    expect_v(6, 8'h3C, 1, "p6_out6");
    expect_v(3, 8'hF0, 1, "p6_out3_kept");
    step();
    we = 1'b0; commit = 1'b0; sel = 3'd3;

    // Watchdog: commit in the expiry cycle prevents the fault
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (15) step();
    commit = 1'b1;
    expect_v(SIG_FAULT, 8'h00, 1, "wdt_expiry_commit_nofault");
    expect_v(3, 8'hF0, 1, "wdt_expiry_commit_out3");
    step();
    commit = 1'b0;

    // Watchdog: 16 cycles without commit raises the fault
    expect_v(SIG_FAULT, 8'h00, 15, "wdt_before_expiry");
    expect_v(3, 8'hF0, 15, "wdt_out3_before");
    expect_v(SIG_FAULT, 8'h01, 16, "wdt_fault_set");
    expect_v(3, 8'h00, 16, "wdt_out3_safe");
    expect_v(6, 8'h3C - 8'h3C, 16, "wdt_out6_safe");
    repeat (16) step();

    // Fault: commit ignored, shadow writes continue
    sel = 3'd3; op = 2'b00; data_in = 8'h55; we = 1'b1; commit = 1'b1;
    expect_v(3, 8'h00, 1, "fault_commit_out3_held");
    expect_v(SIG_FAULT, 8'h01, 1, "fault_still_set");
    expect_v(SIG_RD, 8'h55, 2, "fault_write_rd");
    step();
    we = 1'b0; commit = 1'b0;
    step();
    clear_fault = 1'b1;
    expect_v(SIG_FAULT, 8'h00, 1, "clear_fault_flag");
    expect_v(3, 8'h00, 1, "clear_out3_still_safe");
    step();
    clear_fault = 1'b0; commit = 1'b1;
    expect_v(3, 8'h55, 1, "recover_out3");
    expect_v(6, 8'h3C, 1, "recover_out6");
    expect_v(0, 8'h00, 1, "recover_out0");
    step();
    commit = 1'b0;

    n_check++;
    if (out3 !== 8'h55) begin
      n_fail++;
      $display("FAIL direct_recover_out3: got %02h", out3);
    end
    n_check++;
    if (out6 !== 8'h3C) begin
      n_fail++;
      $display("FAIL direct_recover_out6: got %02h", out6);
    end

    // Reset in the same cycle as a write to port 5
    sel = 3'd5; op = 2'b00; data_in = 8'h11; we = 1'b1;
    step();
    data_in = 8'h77; rst_n = 1'b0;
    expect_v(SIG_RD, 8'h00, 1, "rst_mid_rd");
    expect_v(3, 8'h00, 1, "rst_mid_out3");
    expect_v(SIG_FAULT, 8'h00, 1, "rst_mid_fault");
    step();
    rst_n = 1'b1; we = 1'b0;
    expect_v(SIG_RD, 8'h00, 1, "rst_mid_shadow5");
    step();

    n_check++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL direct_rst_mid_rd: got %02h", rd_data);
    end
    n_check++;
    if (wdt_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_rst_mid_fault: got %b", wdt_fault);
    end

    repeat (3) step();
    foreach (sbq[i]) begin
      n_check++;
      n_fail++;
      $display("FAIL %s: never compared (due cyc %0d)", sbq[i].name, sbq[i].due);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
